// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forwarding selects, FSM codes,
// and the scoreboard entry layout.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [1:0] HZ_RUN   = 2'd0;
    localparam logic [1:0] HZ_STALL = 2'd1;
    localparam logic [1:0] HZ_FLUSH = 2'd2;

    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    // x0 writes are never tracked, so x0 can never produce a hazard.
    function automatic sb_entry_t make_entry(input logic [4:0] rd, input logic wen,
                                             input logic is_load);
        sb_entry_t e;
        e.valid   = wen && (rd != 5'd0);
        e.rd      = rd;
        e.is_load = is_load;
        return e;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [2:0] m, input logic ex_is_load);
        logic [1:0] sel;
        sel = FWD_RF;
        if (m[SB_EX] && !ex_is_load) begin
            sel = FWD_MEM;
        end else if (m[SB_MEM]) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against the EX/MEM/WB scoreboard entries.
module hazard_match
    import hazard_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic       use_i,
    input  logic [4:0] addr_i,
    input  sb_entry_t  ex_i,
    input  sb_entry_t  mem_i,
    input  sb_entry_t  wb_i,
    output logic [2:0] match_o
);

    function automatic logic hit(input logic use_f, input logic [4:0] addr,
                                 input sb_entry_t e);
        return use_f && (addr != 5'd0) && e.valid && (e.rd[AW-1:0] == addr[AW-1:0]);
    endfunction

    assign match_o[SB_EX]  = hit(use_i, addr_i, ex_i);
    assign match_o[SB_MEM] = hit(use_i, addr_i, mem_i);
    assign match_o[SB_WB]  = hit(use_i, addr_i, wb_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: stall/flush/freeze plus
// registered EX forwarding selects. Define FORWARDING_EN to enable forwarding.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN_REGS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rd_addr,
    input  logic       id_rf_wen,
    input  logic       id_is_load,
    input  logic       ex_br_taken,
    input  logic       dmem_busy,
    output logic       if_stall,
    output logic       if_flush,
    output logic       id_flush,
    output logic       freeze,
    output logic [1:0] ex_fwd_rs1,
    output logic [1:0] ex_fwd_rs2,
    output logic [1:0] dbg_state
);

    localparam int AW = $clog2(XLEN_REGS);

    sb_entry_t  sb_ex_q, sb_mem_q, sb_wb_q, sb_ex_d;
    logic [1:0] state_q, state_d;
    logic [2:0] m1, m2;
    logic       raw_hazard;

    hazard_match #(.AW(AW)) u_match_rs1 (
        .use_i   (id_valid && id_use_rs1),
        .addr_i  (id_rs1_addr),
        .ex_i    (sb_ex_q),
        .mem_i   (sb_mem_q),
        .wb_i    (sb_wb_q),
        .match_o (m1)
    );

    hazard_match #(.AW(AW)) u_match_rs2 (
        .use_i   (id_valid && id_use_rs2),
        .addr_i  (id_rs2_addr),
        .ex_i    (sb_ex_q),
        .mem_i   (sb_mem_q),
        .wb_i    (sb_wb_q),
        .match_o (m2)
    );

    // WB matches are covered by the write-first register file.
    logic unused_sb;

`ifdef FORWARDING_EN
    assign raw_hazard = (m1[SB_EX] || m2[SB_EX]) && sb_ex_q.is_load;
    assign unused_sb  = ^{m1[SB_WB], m2[SB_WB], sb_mem_q.is_load, sb_wb_q.is_load};
`else
    assign raw_hazard = m1[SB_EX] || m1[SB_MEM] || m2[SB_EX] || m2[SB_MEM];
    assign unused_sb  = ^{m1[SB_WB], m2[SB_WB], sb_ex_q.is_load,
                          sb_mem_q.is_load, sb_wb_q.is_load};
`endif

    // Priority: memory busy freezes everything, then branch redirect, then stall.
    always_comb begin
        freeze   = 1'b0;
        if_stall = 1'b0;
        if_flush = 1'b0;
        id_flush = 1'b0;
        state_d  = state_q;
        if (dmem_busy) begin
            freeze = 1'b1;
        end else if (ex_br_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
            state_d  = HZ_FLUSH;
        end else if (raw_hazard) begin
            if_stall = 1'b1;
            id_flush = 1'b1;
            state_d  = HZ_STALL;
        end else begin
            state_d  = HZ_RUN;
        end
    end

    always_comb begin
        sb_ex_d = '0;
        if (id_valid && !id_flush) begin
            sb_ex_d = make_entry(id_rd_addr, id_rf_wen, id_is_load);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_ex_q  <= '0;
            sb_mem_q <= '0;
            sb_wb_q  <= '0;
            state_q  <= HZ_RUN;
        end else if (!freeze) begin
            sb_ex_q  <= sb_ex_d;
            sb_mem_q <= sb_ex_q;
            sb_wb_q  <= sb_mem_q;
            state_q  <= state_d;
        end
    end

    assign dbg_state = state_q;

`ifdef FORWARDING_EN
    logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

    assign fwd1_d = id_flush ? FWD_RF : fwd_sel(m1, sb_ex_q.is_load);
    assign fwd2_d = id_flush ? FWD_RF : fwd_sel(m2, sb_ex_q.is_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd1_q <= FWD_RF;
            fwd2_q <= FWD_RF;
        end else if (!freeze) begin
            fwd1_q <= fwd1_d;
            fwd2_q <= fwd2_d;
        end
    end

    assign ex_fwd_rs1 = fwd1_q;
    assign ex_fwd_rs2 = fwd2_q;
`else
    assign ex_fwd_rs1 = FWD_RF;
    assign ex_fwd_rs2 = FWD_RF;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Consumes the decoded fields of the instruction in ID: rs1/rs2 addresses, rd address, rf_wen and wb_sel.
- Keeps its own scoreboard of the writers in flight in EX, MEM and WB.
- Drives stall, flush and freeze controls for the pipeline registers, plus registered forwarding selects for the EX-stage operand muxes.

Parameters:
- XLEN_REGS, 32, number of architectural registers (address width fixed at 5).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction (0 = bubble)
- id_rs1_addr  in  5  decoded rs1 address
- id_rs2_addr  in  5  decoded rs2 address
- id_use_rs1  in  1  ID instruction reads rs1 (0 for LUI/AUIPC/JAL)
- id_use_rs2  in  1  ID instruction reads rs2 (R-type, store, branch only)
- id_rd_addr  in  5  decoded rd address
- id_rf_wen  in  1  decoded rf_wen
- id_is_load  in  1  wb_sel == WB_MEM
- ex_br_taken  in  1  branch/jump in EX redirects PC this cycle
- dmem_busy  in  1  data memory not ready; whole pipeline must hold
- if_stall  out  1  hold PC and IF/ID register
- if_flush  out  1  clear IF/ID to bubble
- id_flush  out  1  load bubble into ID/EX instead of the ID instruction
- freeze  out  1  hold every pipeline register, including this block's scoreboard
- ex_fwd_rs1  out  2  operand-1 source for the instruction now in EX
- ex_fwd_rs2  out  2  operand-2 source for the instruction now in EX

Behaviour:
- Reset (async, rst=1): all scoreboard entries invalid; ex_fwd_rs1/rs2 = FWD_RF; state = RUN. The combinational outputs then evaluate to 0.
- Scoreboard: three entries (EX, MEM, WB), each holding {valid, rd, is_load}.
  - An entry is valid only if rf_wen=1 and rd!=0.
  - Each non-frozen cycle: WB<=MEM, MEM<=EX, EX<=ID fields.
  - EX entry loads invalid when id_flush=1 or id_valid=0.
- Match rule: a source matches an entry iff the entry is valid, the use flag is 1, and the addresses are equal. x0 never matches.
- Load-use: an ID source matches the EX entry and that entry has is_load=1.
  - Response: if_stall=1, id_flush=1 for exactly 1 cycle.
  - Next cycle the load sits in MEM, no match persists, and the instruction proceeds.
- Forwarding (registered, applied when ID advances into EX): per source, evaluated in priority order.
  - Match against EX entry (non-load) -> FWD_MEM.
  - Else match against MEM entry -> FWD_WB.
  - Else -> FWD_RF.
  - WB-entry matches need nothing: the register file is write-first.
  - When id_flush=1, the selects load FWD_RF.
- Branch: ex_br_taken=1 -> if_flush=1, id_flush=1, if_stall=0 in the same cycle. It overrides any load-use stall.
- Freeze: dmem_busy=1 -> freeze=1, and all other outputs = 0. Scoreboard and fwd registers hold.
  - ex_br_taken stays asserted by the pipeline until freeze drops; the flush then fires.
- FSM states:
  - RUN.
  - STALL: entered on load-use; lasts 1 cycle; returns to RUN.
  - FLUSH: entered on taken branch; lasts 1 cycle; returns to RUN.
  - Any state -> same state while freeze=1.
  - A second load-use directly from STALL is impossible by construction. If one occurs, the bench flags it as an error.
- All controls except the fwd selects are combinational from the ID inputs, the scoreboard and the branch/busy inputs. Latency is 0 cycles.

Optional Feature:
- FORWARDING_EN defined: forwarding as above.
- Undefined:
  - ex_fwd_rs1/rs2 are tied to FWD_RF.
  - Any ID source matching a valid EX or MEM entry (load or not) -> if_stall=1, id_flush=1, repeated each cycle until no match.
  - FSM stays in STALL for multiple cycles.

Decomposition:
- Added to define.vh:
  - FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2.
  - HZ_RUN, HZ_STALL, HZ_FLUSH state codes.
- One sub-module, hazard_match: for one source against three scoreboard entries, returns the match vector; instantiated twice.

Test Plan:
- lw x5,0(x1); add x6,x5,x2 -> 1 cycle if_stall=1/id_flush=1; add enters EX with ex_fwd_rs1=FWD_WB.
- addi x5,x0,3; sub x7,x5,x5 -> no stall; ex_fwd_rs1=ex_fwd_rs2=FWD_MEM.
- addi x5..; nop; or x8,x5,x0 -> ex_fwd_rs1=FWD_WB; addi x0,x0,1 followed by user of x0 -> FWD_RF, no stall.
- Load-use hazard and ex_br_taken=1 in the same cycle -> if_flush=id_flush=1, if_stall=0; next cycle the scoreboard EX entry is invalid.
- dmem_busy=1 for 3 cycles during a load-use -> freeze=1, stall=0, scoreboard held; after release, 1 stall cycle occurs.
- Without FORWARDING_EN: addi x5; add x6,x5,x0 -> if_stall held 2 cycles, then FWD_RF.
- rst asserted mid-STALL -> all outputs 0 and state RUN immediately, without waiting for a clock edge.
